// File: rtl/fifo_flags_if.sv
// Producer/consumer-facing signal bundle for fifo_flags: write/read requests, data and status flags.
// The FIFO takes the slave side; the surrounding logic (or a bench) takes the master side.
interface fifo_flags_if #(
    parameter int DATA_W    = 10,
    parameter int FIFO_SIZE = 6
);
    localparam int CNT_W = $clog2(FIFO_SIZE + 1);

    logic              write;
    logic              read;
    logic [DATA_W-1:0] datain;
    logic              clr_err;
    logic [DATA_W-1:0] dataout;
    logic              val;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output write, read, datain, clr_err,
        input  dataout, val, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  write, read, datain, clr_err,
        output dataout, val, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flags.sv
// Single-clock FIFO of arbitrary depth with occupancy count, almost-full/empty thresholds and sticky errors.
// Latency: count/flags 1 cycle after the accepting edge; read data 1 cycle (FWFT=0) or 0 cycles (FWFT=1).
// Backpressure: a write is refused when full unless a read is accepted in the same cycle; refusals are flagged.
module fifo_flags #(
    parameter int DATA_W    = 10,
    parameter int FIFO_SIZE = 6,
    parameter int AF_LEVEL  = FIFO_SIZE - 1,
    parameter int AE_LEVEL  = 1,
    parameter bit FWFT      = 1'b0,
    localparam int CNT_W    = $clog2(FIFO_SIZE + 1)
) (
    input  logic        clock,
    input  logic        reset_n,
    fifo_flags_if.slave bus
);
    localparam int PTR_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_SIZE);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [FIFO_SIZE];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              val_q, val_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              is_full, is_empty, rd_ok, wr_ok;

    // Flags come only from the registered count, so request inputs never reach them combinationally.
    assign is_full  = (cnt_q == CNT_FULL);
    assign is_empty = (cnt_q == '0);
    assign rd_ok    = bus.read && !is_empty;
    assign wr_ok    = bus.write && (!is_full || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        val_d    = 1'b0;
        // Explicit wrap keeps non-power-of-two depths correct.
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            dout_d   = mem_q[rd_ptr_q];
            val_d    = 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // A new error in the same cycle as clr_err leaves the flag set.
        ovf_d = (bus.write && !wr_ok) || (ovf_q && !bus.clr_err);
        udf_d = (bus.read && !rd_ok) || (udf_q && !bus.clr_err);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            val_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            val_q    <= val_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= bus.datain;
        end
    end

    // In FWFT mode the head entry is shown directly; gating on empty hides stale storage.
    assign bus.dataout      = FWFT ? (is_empty ? '0 : mem_q[rd_ptr_q]) : dout_q;
    assign bus.val          = FWFT ? !is_empty : val_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (cnt_q >= CNT_AF);
    assign bus.almost_empty = (cnt_q <= CNT_AE);
    assign bus.count        = cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: a registered-read instance and an FWFT instance, scoreboarded against a queue model.
module tb_fifo_flags;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    fifo_flags_if #(.DATA_W(10), .FIFO_SIZE(6)) a_if ();
    fifo_flags_if #(.DATA_W(10), .FIFO_SIZE(6)) b_if ();

    fifo_flags #(.DATA_W(10), .FIFO_SIZE(6), .AF_LEVEL(5), .AE_LEVEL(1), .FWFT(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(a_if));
    fifo_flags #(.DATA_W(10), .FIFO_SIZE(6), .AF_LEVEL(5), .AE_LEVEL(1), .FWFT(1'b1)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(b_if));

    int vecs = 0;
    int errs = 0;
    logic [9:0] mdl[$];
    logic [9:0] exp_q[$];
    logic [9:0] last_dout = '0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one cycle on instance A and advances the reference model; no comparisons here.
    task automatic drive_a(input bit wr, input bit rd, input bit clr, input logic [9:0] din);
        bit rd_ok, wr_ok;
        rd_ok = rd && (mdl.size() > 0);
        wr_ok = wr && ((mdl.size() < 6) || rd_ok);
        a_if.write = wr; a_if.read = rd; a_if.clr_err = clr; a_if.datain = din;
        if (rd_ok) exp_q.push_back(mdl.pop_front());
        if (wr_ok) mdl.push_back(din);
        m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
        m_udf = (rd && !rd_ok) || (m_udf && !clr);
        step();
        a_if.write = 1'b0; a_if.read = 1'b0; a_if.clr_err = 1'b0;
    endtask

    function automatic logic [8:0] exp_flags_a();
        int n;
        n = mdl.size();
        return {n == 6, n == 0, n >= 5, n <= 1, m_ovf, m_udf, 3'(n)};
    endfunction

    task automatic test_reset();
        a_if.write = 0; a_if.read = 0; a_if.clr_err = 0; a_if.datain = '0;
        b_if.write = 0; b_if.read = 0; b_if.clr_err = 0; b_if.datain = '0;
        reset_n = 1'b0;
        #2;
        vecs++;
        if ({a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.val, a_if.overflow,
             a_if.underflow, a_if.count, a_if.dataout} !== {7'b0101000, 3'd0, 10'd0}) begin
            errs++;
            $display("FAIL reset_state: f/e/af/ae/val/ovf/udf=%b%b%b%b%b%b%b cnt=%0d dout=%0d, want 0101000 cnt=0 dout=0",
                     a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.val,
                     a_if.overflow, a_if.underflow, a_if.count, a_if.dataout);
        end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        logic [8:0] ef;
        for (int i = 1; i <= 3; i++) begin
            drive_a(1'b1, 1'b0, 1'b0, 10'(i));
            ef = exp_flags_a();
            vecs++;
            if ({a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.overflow,
                 a_if.underflow, a_if.count} !== ef || a_if.val !== 1'b0) begin
                errs++;
                $display("FAIL fill_flags[%0d]: flags=%b val=%b, want flags=%b val=0", i,
                         {a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.overflow,
                          a_if.underflow, a_if.count}, a_if.val, ef);
            end
        end
    endtask

    task automatic test_read_underflow();
        logic [9:0] e;
        logic [8:0] ef;
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b0, 1'b1, 1'b0, '0);
            vecs++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_dout = e;
                if (a_if.val !== 1'b1 || a_if.dataout !== e) begin
                    errs++;
                    $display("FAIL read_data[%0d]: val=%b dout=%0d, want val=1 dout=%0d", k, a_if.val, a_if.dataout, e);
                end
            end else if (a_if.val !== 1'b0 || a_if.dataout !== last_dout) begin
                errs++;
                $display("FAIL read_hold[%0d]: val=%b dout=%0d, want val=0 dout=%0d", k, a_if.val, a_if.dataout, last_dout);
            end
            ef = exp_flags_a();
            vecs++;
            if ({a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.overflow,
                 a_if.underflow, a_if.count} !== ef) begin
                errs++;
                $display("FAIL read_flags[%0d]: got %b want %b", k,
                         {a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.overflow,
                          a_if.underflow, a_if.count}, ef);
            end
            step();
            vecs++;
            if (a_if.val !== 1'b0) begin
                errs++;
                $display("FAIL read_val_pulse[%0d]: val=%b, want 0", k, a_if.val);
            end
        end
        drive_a(1'b0, 1'b0, 1'b1, '0);
        vecs++;
        if (a_if.underflow !== 1'b0) begin
            errs++;
            $display("FAIL clr_underflow: underflow=%b, want 0", a_if.underflow);
        end
    endtask

    task automatic test_full_overflow();
        logic [8:0] ef;
        for (int i = 1; i <= 7; i++) begin
            drive_a(1'b1, 1'b0, 1'b0, 10'(11 * i));
            ef = exp_flags_a();
            vecs++;
            if ({a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.overflow,
                 a_if.underflow, a_if.count} !== ef) begin
                errs++;
                $display("FAIL fill_to_full[%0d]: got %b want %b", i,
                         {a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.overflow,
                          a_if.underflow, a_if.count}, ef);
            end
        end
    endtask

    task automatic test_full_rw();
        logic [9:0] e;
        logic [8:0] ef;
        logic [9:0] order [7];
        order = '{10'd11, 10'd22, 10'd33, 10'd44, 10'd55, 10'd66, 10'd88};
        drive_a(1'b0, 1'b0, 1'b1, '0);
        drive_a(1'b1, 1'b1, 1'b0, 10'd88);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) drive_a(1'b0, 1'b1, 1'b0, '0);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
            last_dout = e;
            vecs++;
            if (a_if.val !== 1'b1 || a_if.dataout !== order[k] || e !== order[k]) begin
                errs++;
                $display("FAIL full_rw_order[%0d]: val=%b dout=%0d, want val=1 dout=%0d", k, a_if.val, a_if.dataout, order[k]);
            end
            ef = exp_flags_a();
            vecs++;
            if ({a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.overflow,
                 a_if.underflow, a_if.count} !== ef) begin
                errs++;
                $display("FAIL full_rw_flags[%0d]: got %b want %b", k,
                         {a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.overflow,
                          a_if.underflow, a_if.count}, ef);
            end
        end
    endtask

    task automatic test_fwft();
        logic [9:0] bq[$];
        logic [9:0] e;
        b_if.write = 1'b1; b_if.datain = 10'd5;
        step();
        b_if.write = 1'b0;
        vecs++;
        if (b_if.val !== 1'b1 || b_if.dataout !== 10'd5 || b_if.count !== 3'd1) begin
            errs++;
            $display("FAIL fwft_show: val=%b dout=%0d cnt=%0d, want val=1 dout=5 cnt=1", b_if.val, b_if.dataout, b_if.count);
        end
        b_if.read = 1'b1;
        step();
        b_if.read = 1'b0;
        vecs++;
        if (b_if.val !== 1'b0 || b_if.empty !== 1'b1) begin
            errs++;
            $display("FAIL fwft_consume: val=%b empty=%b, want val=0 empty=1", b_if.val, b_if.empty);
        end
        for (int i = 0; i < 10; i++) begin
            b_if.write = 1'b1; b_if.datain = 10'(100 + i);
            bq.push_back(10'(100 + i));
            b_if.read = (i > 0);
            if (i > 0) begin
                e = bq.pop_front();
                vecs++;
                if (b_if.val !== 1'b1 || b_if.dataout !== e) begin
                    errs++;
                    $display("FAIL fwft_b2b_data[%0d]: val=%b dout=%0d, want val=1 dout=%0d", i, b_if.val, b_if.dataout, e);
                end
            end
            step();
            vecs++;
            if (b_if.count !== 3'd1) begin
                errs++;
                $display("FAIL fwft_b2b_count[%0d]: cnt=%0d, want 1", i, b_if.count);
            end
        end
        b_if.write = 1'b0; b_if.read = 1'b1;
        e = bq.pop_front();
        vecs++;
        if (b_if.dataout !== e) begin
            errs++;
            $display("FAIL fwft_last: dout=%0d, want %0d", b_if.dataout, e);
        end
        step();
        b_if.read = 1'b0;
        vecs++;
        if (b_if.empty !== 1'b1 || b_if.val !== 1'b0) begin
            errs++;
            $display("FAIL fwft_drained: empty=%b val=%b, want empty=1 val=0", b_if.empty, b_if.val);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) drive_a(1'b1, 1'b0, 1'b0, 10'(200 + i));
        drive_a(1'b0, 1'b1, 1'b0, '0);
        drive_a(1'b0, 1'b1, 1'b0, '0);
        vecs++;
        if (a_if.count !== 3'd4 || a_if.overflow !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset: cnt=%0d ovf=%b, want cnt=4 ovf=1", a_if.count, a_if.overflow);
        end
        #3;
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.val, a_if.overflow,
             a_if.underflow, a_if.count, a_if.dataout} !== {7'b0101000, 3'd0, 10'd0}) begin
            errs++;
            $display("FAIL async_reset: f/e/af/ae/val/ovf/udf=%b%b%b%b%b%b%b cnt=%0d dout=%0d, want 0101000 cnt=0 dout=0",
                     a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty, a_if.val,
                     a_if.overflow, a_if.underflow, a_if.count, a_if.dataout);
        end
        mdl.delete(); exp_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; last_dout = '0;
        step();
        reset_n = 1'b1;
        drive_a(1'b1, 1'b0, 1'b0, 10'd7);
        drive_a(1'b0, 1'b1, 1'b0, '0);
        vecs++;
        if (a_if.val !== 1'b1 || a_if.dataout !== 10'd7 || exp_q.size() != 1) begin
            errs++;
            $display("FAIL post_reset_read: val=%b dout=%0d, want val=1 dout=7", a_if.val, a_if.dataout);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_read_underflow();
        test_full_overflow();
        test_full_rw();
        test_fwft();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
